// File: rtl/sdram_tg_pkg.sv
// sdram_tg_pkg: shared types, LFSR taps and LFSR step for the SDRAM traffic generator.
package sdram_tg_pkg;
    typedef enum logic [2:0] {IDLE, WREQ, WDROP, RREQ, RDROP, FINISH} state_t;
    typedef enum logic [1:0] {PAT_ADDR, PAT_INV_ADDR, PAT_LFSR, PAT_CONST} pattern_t;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction
endpackage

// File: rtl/sdram_traffic_gen_if.sv
// sdram_traffic_gen_if: request/ack port between the traffic generator and sdram_controller.
interface sdram_traffic_gen_if #(parameter int DATA_W = 128, parameter int ADDR_W = 22);
    logic              owrite_req, iwrite_ack, oread_req, iread_ack;
    logic [ADDR_W-1:0] owrite_address, oread_address;
    logic [DATA_W-1:0] owrite_data, iread_data;
    modport master(output owrite_req, owrite_address, owrite_data, oread_req, oread_address,
                   input iwrite_ack, iread_data, iread_ack);
    modport slave(input owrite_req, owrite_address, owrite_data, oread_req, oread_address,
                  output iwrite_ack, iread_data, iread_ack);
endinterface

// File: rtl/sdram_pattern_gen.sv
// sdram_pattern_gen: holds the LFSR and forms the write/expected word; shared by write and read phases.
module sdram_pattern_gen
    import sdram_tg_pkg::*;
#(parameter int DATA_W = 128, parameter int ADDR_W = 22) (
    input  logic              clk,
    input  logic              rst_n,
    input  pattern_t          pattern,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       seed,
    input  logic [DATA_W-1:0] const_data,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] word
);
    logic [31:0]       lfsr;
    logic [DATA_W-1:0] addr_word;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr <= 32'd1;
        else if (load) lfsr <= (seed == 32'd0) ? 32'd1 : seed;
        else if (advance) lfsr <= lfsr_next(lfsr);
    assign addr_word = DATA_W'(addr);
    always_comb
        word = (pattern == PAT_ADDR)     ? addr_word :
               (pattern == PAT_INV_ADDR) ? ~addr_word :
               (pattern == PAT_LFSR)     ? {(DATA_W/32){lfsr}} : const_data;
endmodule

// File: rtl/sdram_traffic_gen.sv
// sdram_traffic_gen: single write/read and write-then-verify sweep driver for the sdram_controller port,
// with mismatch counting and a per-phase watchdog.
module sdram_traffic_gen
    import sdram_tg_pkg::*;
#(
    parameter int DATA_W         = 128,
    parameter int ADDR_W         = 22,
    parameter int ERR_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                iclk,
    input  logic                ireset_n,
    input  logic                istart_write,
    input  logic                istart_read,
    input  logic                istart_sweep,
    input  logic [ADDR_W-1:0]   isingle_addr,
    input  logic [DATA_W-1:0]   isingle_data,
    input  logic [ADDR_W-1:0]   isweep_base,
    input  logic [ADDR_W-1:0]   isweep_len,
    input  logic [1:0]          ipattern,
    input  logic [31:0]         iseed,
    sdram_traffic_gen_if.master ctrl,
    output logic                obusy,
    output logic                odone,
    output logic                opass,
    output logic                otimeout,
    output logic [ERR_W-1:0]    oerr_count,
    output logic [ADDR_W-1:0]   ofirst_err_addr,
    output logic [DATA_W-1:0]   oread_data
);
    state_t            state, state_n;
    pattern_t          pattern;
    logic              sweep, start, last, waiting, timeout_hit, load, advance, mismatch;
    logic [ADDR_W-1:0] single_addr, base, len, idx, addr;
    logic [DATA_W-1:0] const_data, word;
    logic [31:0]       seed, wd;

    assign start       = state == IDLE && (istart_sweep || istart_write || istart_read);
    assign addr        = sweep ? base + idx : single_addr;
    assign last        = idx == len - ADDR_W'(1);
    assign waiting     = (state == WREQ && !ctrl.iwrite_ack) || (state == WDROP && ctrl.iwrite_ack) ||
                         (state == RREQ && !ctrl.iread_ack) || (state == RDROP && ctrl.iread_ack);
    assign timeout_hit = TIMEOUT_CYCLES != 0 && waiting && wd == 32'(TIMEOUT_CYCLES) - 32'd1;
    assign load        = start || (state == WDROP && !ctrl.iwrite_ack && sweep && last);
    assign advance     = (state == WREQ && ctrl.iwrite_ack) || (state == RREQ && ctrl.iread_ack);
    assign mismatch    = sweep && state == RREQ && ctrl.iread_ack && ctrl.iread_data != word;

    sdram_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pat (
        .clk(iclk), .rst_n(ireset_n), .pattern(pattern), .addr(addr),
        .seed(state == IDLE ? iseed : seed), .const_data(const_data),
        .load(load), .advance(advance), .word(word)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !start ? IDLE : (istart_sweep && isweep_len == '0) ? FINISH :
                               (istart_sweep || istart_write) ? WREQ : RREQ;
            WREQ:    state_n = ctrl.iwrite_ack ? WDROP : WREQ;
            WDROP:   state_n = ctrl.iwrite_ack ? WDROP : !sweep ? FINISH : last ? RREQ : WREQ;
            RREQ:    state_n = ctrl.iread_ack ? RDROP : RREQ;
            RDROP:   state_n = ctrl.iread_ack ? RDROP : (sweep && !last) ? RREQ : FINISH;
            default: state_n = IDLE;
        endcase
        if (timeout_hit) state_n = FINISH;
    end

    always_ff @(posedge iclk or negedge ireset_n)
        if (!ireset_n) begin
            state           <= IDLE;
            wd              <= '0;
            sweep           <= 1'b0;
            pattern         <= PAT_ADDR;
            single_addr     <= '0;
            base            <= '0;
            len             <= '0;
            idx             <= '0;
            const_data      <= '0;
            seed            <= '0;
            opass           <= 1'b0;
            otimeout        <= 1'b0;
            oerr_count      <= '0;
            ofirst_err_addr <= '0;
            oread_data      <= '0;
        end else begin
            state <= state_n;
            wd    <= waiting ? wd + 32'd1 : '0;
            if (start) begin
                sweep           <= istart_sweep;
                pattern         <= istart_sweep ? pattern_t'(ipattern) : PAT_CONST;
                single_addr     <= isingle_addr;
                const_data      <= isingle_data;
                base            <= isweep_base;
                len             <= isweep_len;
                seed            <= iseed;
                idx             <= '0;
                opass           <= 1'b1;
                otimeout        <= 1'b0;
                oerr_count      <= '0;
                ofirst_err_addr <= '0;
            end
            if ((state == WDROP && !ctrl.iwrite_ack) || (state == RDROP && !ctrl.iread_ack))
                idx <= last ? '0 : idx + ADDR_W'(1);
            if (state == RREQ && ctrl.iread_ack) oread_data <= ctrl.iread_data;
            if (mismatch) begin
                opass <= 1'b0;
                if (oerr_count != '1) oerr_count <= oerr_count + ERR_W'(1);
                if (oerr_count == '0) ofirst_err_addr <= addr;
            end
            if (timeout_hit) begin
                opass    <= 1'b0;
                otimeout <= 1'b1;
            end
        end

    assign ctrl.owrite_req     = state == WREQ;
    assign ctrl.oread_req      = state == RREQ;
    assign ctrl.owrite_address = addr;
    assign ctrl.oread_address  = addr;
    assign ctrl.owrite_data    = word;
    assign obusy               = state != IDLE;
    assign odone               = state == FINISH;
endmodule

// File: tb/tb_sdram_traffic_gen.sv
// tb_sdram_traffic_gen: randomized scoreboard bench with a controller model and a
// pattern/compare reference model of the sweep rules.
module tb_sdram_traffic_gen;
    localparam int DW = 128, AW = 22, EW = 16, TO = 16;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic pass; logic tmo; logic [EW-1:0] err; logic [AW-1:0] first; logic [DW-1:0] rdata; } st_t;

    logic iclk = 0, ireset_n = 0;
    logic istart_write = 0, istart_read = 0, istart_sweep = 0;
    logic [AW-1:0] isingle_addr = '0, isweep_base = '0, isweep_len = '0;
    logic [DW-1:0] isingle_data = '0;
    logic [1:0] ipattern = '0;
    logic [31:0] iseed = '0;
    logic obusy, odone, opass, otimeout;
    logic [EW-1:0] oerr_count;
    logic [AW-1:0] ofirst_err_addr;
    logic [DW-1:0] oread_data;

    sdram_traffic_gen_if #(.DATA_W(DW), .ADDR_W(AW)) ctrl();

    sdram_traffic_gen #(.DATA_W(DW), .ADDR_W(AW), .ERR_W(EW), .TIMEOUT_CYCLES(TO)) dut (
        .iclk(iclk), .ireset_n(ireset_n), .istart_write(istart_write), .istart_read(istart_read),
        .istart_sweep(istart_sweep), .isingle_addr(isingle_addr), .isingle_data(isingle_data),
        .isweep_base(isweep_base), .isweep_len(isweep_len), .ipattern(ipattern), .iseed(iseed),
        .ctrl(ctrl), .obusy(obusy), .odone(odone), .opass(opass), .otimeout(otimeout),
        .oerr_count(oerr_count), .ofirst_err_addr(ofirst_err_addr), .oread_data(oread_data)
    );

    always #5 iclk = ~iclk;

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0, wreq_len = 0, wreq_run = 0;
    int lat = 2;
    bit noack = 0;
    wr_t exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    st_t exp_st[$];
    logic [AW-1:0] faults[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] shadow [logic [AW-1:0]];
    logic [DW-1:0] last_rdata = '0;

    always @(posedge iclk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h80200003;
        return n;
    endfunction

    function automatic logic [DW-1:0] ref_word(input logic [1:0] pat, input logic [AW-1:0] a,
                                              input logic [31:0] l, input logic [DW-1:0] c);
        case (pat)
            2'd0:    return DW'(a);
            2'd1:    return ~DW'(a);
            2'd2:    return {(DW/32){l}};
            default: return c;
        endcase
    endfunction

    function automatic bit is_fault(input logic [AW-1:0] a);
        foreach (faults[i]) if (faults[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
        return (shadow.exists(a) ? shadow[a] : '0) ^ (is_fault(a) ? DW'(1) : '0);
    endfunction

    function automatic void push_st(input logic p, input logic t, input logic [EW-1:0] e,
                                    input logic [AW-1:0] f, input logic [DW-1:0] r);
        st_t s;
        s.pass = p; s.tmo = t; s.err = e; s.first = f; s.rdata = r;
        exp_st.push_back(s);
    endfunction

    // Controller model: acks after lat cycles, holds ack until req falls, optional bit-0 read faults.
    initial begin
        int wcnt, rcnt;
        wcnt = 0; rcnt = 0;
        ctrl.iwrite_ack = 0; ctrl.iread_ack = 0; ctrl.iread_data = '0;
        forever begin
            @(negedge iclk);
            if (!ireset_n) begin
                wcnt = 0; rcnt = 0; ctrl.iwrite_ack = 0; ctrl.iread_ack = 0;
                continue;
            end
            if (ctrl.owrite_req && !ctrl.iwrite_ack) begin
                wcnt++;
                if (!noack && wcnt >= lat) begin
                    mem[ctrl.owrite_address] = ctrl.owrite_data;
                    ctrl.iwrite_ack = 1; wcnt = 0;
                end
            end else if (!ctrl.owrite_req) ctrl.iwrite_ack = 0;
            if (ctrl.oread_req && !ctrl.iread_ack) begin
                rcnt++;
                if (!noack && rcnt >= lat) begin
                    ctrl.iread_data = (mem.exists(ctrl.oread_address) ? mem[ctrl.oread_address] : '0) ^
                                      (is_fault(ctrl.oread_address) ? DW'(1) : '0);
                    ctrl.iread_ack = 1; rcnt = 0;
                end
            end else if (!ctrl.oread_req) ctrl.iread_ack = 0;
        end
    end

    // Monitor: pops the scoreboard on every req rise and every odone.
    initial begin
        logic pw, pr;
        wr_t w;
        logic [AW-1:0] ra;
        st_t s;
        pw = 0; pr = 0;
        forever begin
            @(negedge iclk);
            if (ctrl.owrite_req) wreq_run++;
            else if (pw) begin wreq_len = wreq_run; wreq_run = 0; end
            if (ctrl.owrite_req && !pw) begin
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %h, required none", ctrl.owrite_address);
                end else begin
                    w = exp_wr.pop_front();
                    check("write_addr", DW'(ctrl.owrite_address), DW'(w.addr));
                    check("write_data", ctrl.owrite_data, w.data);
                end
            end
            if (ctrl.oread_req && !pr) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got addr %h, required none", ctrl.oread_address);
                end else begin
                    ra = exp_rd.pop_front();
                    check("read_addr", DW'(ctrl.oread_address), DW'(ra));
                end
            end
            if (odone) begin
                done_cnt++; done_cyc = cyc;
                if (exp_st.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got odone, required none");
                end else begin
                    s = exp_st.pop_front();
                    check("done_busy", DW'(obusy), DW'(1));
                    check("pass", DW'(opass), DW'(s.pass));
                    check("timeout", DW'(otimeout), DW'(s.tmo));
                    check("err_count", DW'(oerr_count), DW'(s.err));
                    check("first_err_addr", DW'(ofirst_err_addr), DW'(s.first));
                    check("read_data", oread_data, s.rdata);
                end
            end
            pw = ctrl.owrite_req; pr = ctrl.oread_req;
        end
    end

    task automatic go(input bit sw, input bit wr, input bit rd, input string name);
        int d0, n;
        d0 = done_cnt; n = 0; start_cyc = cyc;
        istart_sweep = sw; istart_write = wr; istart_read = rd;
        @(negedge iclk);
        istart_sweep = 0; istart_write = 0; istart_read = 0;
        while (done_cnt == d0 && n < 3000) begin @(posedge iclk); #1; n++; end
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL %s_done: no odone within %0d cycles", name, n);
        end
        @(negedge iclk);
    endtask

    task automatic op_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit also_read, input string name);
        wr_t w;
        w.addr = a; w.data = d;
        exp_wr.push_back(w); shadow[a] = d;
        push_st(1'b1, 1'b0, '0, '0, last_rdata);
        isingle_addr = a; isingle_data = d;
        go(0, 1, also_read, name);
    endtask

    task automatic op_read(input logic [AW-1:0] a, input string name);
        exp_rd.push_back(a);
        last_rdata = rd_ref(a);
        push_st(1'b1, 1'b0, '0, '0, last_rdata);
        isingle_addr = a;
        go(0, 0, 1, name);
    endtask

    task automatic op_sweep(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic [1:0] pat,
                            input logic [31:0] seed, input logic [DW-1:0] cdata, input bit with_write,
                            input string name);
        logic [DW-1:0] ws[$];
        logic [DW-1:0] got;
        logic [31:0] l;
        logic [AW-1:0] a, first;
        wr_t w;
        int err;
        l = (seed == 0) ? 32'd1 : seed; err = 0; first = '0;
        for (int i = 0; i < int'(len); i++) begin
            a = base + AW'(i);
            w.addr = a; w.data = ref_word(pat, a, l, cdata);
            exp_wr.push_back(w); shadow[a] = w.data; ws.push_back(w.data);
            l = ref_lfsr(l);
        end
        for (int i = 0; i < int'(len); i++) begin
            a = base + AW'(i);
            exp_rd.push_back(a);
            got = rd_ref(a); last_rdata = got;
            if (got != ws[i]) begin
                err++;
                if (err == 1) first = a;
            end
        end
        push_st(err == 0, 1'b0, EW'(err), first, last_rdata);
        isweep_base = base; isweep_len = len; ipattern = pat; iseed = seed; isingle_data = cdata;
        go(1, with_write, 0, name);
    endtask

    initial begin
        wr_t w;
        logic [AW-1:0] b;
        #1;
        check("rst_write_req", DW'(ctrl.owrite_req), '0);
        check("rst_read_req", DW'(ctrl.oread_req), '0);
        check("rst_busy", DW'(obusy), '0);
        check("rst_done", DW'(odone), '0);
        check("rst_pass", DW'(opass), '0);
        check("rst_err", DW'(oerr_count), '0);
        check("rst_write_data", ctrl.owrite_data, '0);
        @(negedge iclk); ireset_n = 1;
        repeat (2) @(negedge iclk);

        op_write(22'h1, 128'h2A5, 0, "single_write");
        op_read(22'h1, "single_read");
        check("single_read_data", oread_data, 128'h2A5);
        op_sweep(22'h3FFFFE, 22'd4, 2'd0, 32'd0, '0, 0, "sweep_wrap");
        op_sweep(22'h100, 22'd5, 2'd2, 32'd0, '0, 0, "sweep_lfsr_seed0");
        check("lfsr_first_word", mem[22'h100], {4{32'h00000001}});

        faults.push_back(22'h10); faults.push_back(22'h12);
        op_sweep(22'h10, 22'd8, 2'd0, 32'd0, '0, 0, "sweep_fault");
        check("fault_err_count", DW'(oerr_count), DW'(2));
        check("fault_first_addr", DW'(ofirst_err_addr), DW'(22'h10));

        // Reset while a read request is outstanding.
        faults.delete(); noack = 1;
        isingle_addr = 22'h5; exp_rd.push_back(22'h5);
        istart_read = 1; @(negedge iclk); istart_read = 0;
        repeat (3) @(negedge iclk);
        check("pre_reset_read_req", DW'(ctrl.oread_req), DW'(1));
        #2 ireset_n = 0; #1;
        check("mid_reset_read_req", DW'(ctrl.oread_req), '0);
        check("mid_reset_busy", DW'(obusy), '0);
        check("mid_reset_pass", DW'(opass), '0);
        check("mid_reset_timeout", DW'(otimeout), '0);
        check("mid_reset_read_data", oread_data, '0);
        @(negedge iclk); ireset_n = 1; last_rdata = '0;
        @(negedge iclk);

        // Watchdog: controller never acks.
        w.addr = 22'h33; w.data = 128'hDEAD;
        exp_wr.push_back(w);
        push_st(1'b0, 1'b1, '0, '0, last_rdata);
        isingle_addr = 22'h33; isingle_data = 128'hDEAD;
        go(0, 1, 0, "timeout");
        check("timeout_req_cycles", DW'(wreq_len), DW'(TO));
        noack = 0;

        isingle_addr = 22'h3A;
        op_sweep(22'h200, 22'd3, 2'd1, 32'd0, 128'h77, 1, "prio_sweep_over_write");
        op_write(22'h21, 128'h1234_5678, 1, "prio_write_over_read");

        op_sweep(22'h20, '0, 2'd0, 32'd0, '0, 0, "sweep_len0");
        check("len0_done_delay", DW'((done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2)), DW'(1));

        for (int k = 0; k < 14; k++) begin
            lat = $urandom_range(1, 3);
            case ($urandom_range(0, 2))
                0: op_write(AW'($urandom_range(0, 63)), {$urandom, $urandom, $urandom, $urandom}, 0, "rand_write");
                1: op_read(AW'($urandom_range(0, 63)), "rand_read");
                default: begin
                    b = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 63)) : AW'(22'h3FFFFC + $urandom_range(0, 3));
                    if ($urandom_range(0, 1) != 0) faults.push_back(b + AW'($urandom_range(0, 3)));
                    op_sweep(b, AW'($urandom_range(1, 6)), 2'($urandom_range(0, 3)), $urandom,
                             {$urandom, $urandom, $urandom, $urandom}, 0, "rand_sweep");
                    faults.delete();
                end
            endcase
        end

        check("leftover_writes", DW'(exp_wr.size()), '0);
        check("leftover_reads", DW'(exp_rd.size()), '0);
        check("leftover_status", DW'(exp_st.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_traffic_gen.md
# sdram_traffic_gen

Parametrised traffic generator and self-checker for the `sdram_controller` request/ack port. It sits between board controls (keys, switches) and the controller's `iwrite_*`/`iread_*` interface. It keeps the original single-word write and single-word read operations. It adds an address-range sweep that writes a selectable pattern, reads the range back, compares each word and reports pass/fail, error count, first failing address and controller timeouts.

## Interface
- `DATA_W`, 128, controller data width; must be a multiple of 32
- `ADDR_W`, 22, controller word-address width
- `ERR_W`, 16, error-counter width
- `TIMEOUT_CYCLES`, 4096, maximum cycles in any single request or drop phase; 0 disables the watchdog
- `iclk` in 1: sole clock; everything is on the rising edge
- `ireset_n` in 1: asynchronous, active-low reset
- `istart_write` in 1: single write of `isingle_data` to `isingle_addr`
- `istart_read` in 1: single read from `isingle_addr`
- `istart_sweep` in 1: full write-then-verify sweep
- `isingle_addr` in ADDR_W: address for single operations
- `isingle_data` in DATA_W: data for single write; also the constant pattern
- `isweep_base` in ADDR_W: first sweep address
- `isweep_len` in ADDR_W: number of sweep words
- `ipattern` in 2: 0 = ADDR, 1 = INV_ADDR, 2 = LFSR, 3 = CONST
- `iseed` in 32: LFSR seed
- `owrite_req` out 1, `owrite_address` out ADDR_W, `owrite_data` out DATA_W, `iwrite_ack` in 1: controller write port
- `oread_req` out 1, `oread_address` out ADDR_W, `iread_data` in DATA_W, `iread_ack` in 1: controller read port
- `obusy` out 1: operation in progress
- `odone` out 1: one-cycle pulse at operation end
- `opass` out 1: last operation had no mismatch and no timeout
- `otimeout` out 1: last operation was aborted by the watchdog
- `oerr_count` out ERR_W: mismatches in the last sweep
- `ofirst_err_addr` out ADDR_W: address of the first mismatch
- `oread_data` out DATA_W: last word returned by the controller

## Operation
- States:
  - IDLE: wait for a start.
  - WREQ: `owrite_req` high, wait for `iwrite_ack`.
  - WDROP: req low, wait for `iwrite_ack` low.
  - RREQ: `oread_req` high, wait for `iread_ack`.
  - RDROP: req low, wait for `iread_ack` low.
  - FINISH: assert `odone`.
- Starts are sampled only in IDLE and ignored while `obusy`=1. When several starts are high together, priority is sweep > write > read.
- Start latches its inputs and clears status. On start: `opass`=1, `otimeout`=0, `oerr_count`=0, `ofirst_err_addr`=0, index=0, LFSR=seed.
- Single write: WREQ → WDROP → FINISH.
- Single read: RREQ → RDROP → FINISH.
  - `oread_data` is captured in the cycle `iread_ack` is sampled high.
  - No compare is made; `opass` stays 1 unless a timeout occurs.
- Sweep, write phase:
  - For index 0..len-1, address = base+index, modulo 2^ADDR_W (wraps).
  - After each WDROP exit, move to the next index. After the last index, reload index=0, reseed the LFSR and enter RREQ.
- Sweep, read phase:
  - Same address order.
  - On ack, compare `iread_data` against the regenerated expected word.
  - On mismatch: `oerr_count` increments, saturating at 2^ERR_W-1; `opass` goes to 0; `ofirst_err_addr` is loaded only on the first mismatch.
- `isweep_len`=0: go straight IDLE → FINISH with `opass`=1 and no requests.
- Patterns, for word address A:
  - ADDR: A zero-extended to DATA_W.
  - INV_ADDR: bitwise NOT of the ADDR word.
  - LFSR: 32-bit Galois LFSR, taps 0x80200003, replicated DATA_W/32 times. A seed of 0 is replaced by 1. The LFSR advances once per accepted word.
  - CONST: `isingle_data`.
- Watchdog:
  - Counter clears on every state change.
  - If it reaches `TIMEOUT_CYCLES` in WREQ, WDROP, RREQ or RDROP: drop the req, set `otimeout`=1 and `opass`=0, go to FINISH.
- Addresses and data are held stable while the corresponding req is high.
- Reset mid-operation: all outputs return to reset values immediately; the controller sees the req fall asynchronously.

## Timing
- Reset values:
  - All req outputs 0, `obusy` 0, `odone` 0.
  - `opass` 0, `otimeout` 0.
  - `oerr_count` 0, `ofirst_err_addr` 0, `oread_data` 0.
  - Address and data outputs 0. State IDLE.
- Start sampled high at edge 0: `obusy` and the req are high after edge 0 (cycle 1).
- Ack sampled high at edge k:
  - Req low from k+1.
  - Read data and compare result registered at edge k.
- Drop state exits on the first edge where ack is sampled low. The next req rises in the cycle after, so there is always at least one req-low cycle between words.
- FINISH lasts exactly one cycle with `odone`=1. `obusy` falls with the return to IDLE.
- Status outputs are stable from `odone` until the next start.
- Best case per word with a one-cycle ack: 3 cycles (REQ, DROP, next REQ).

## Structure
- Package `sdram_tg_pkg` holds:
  - state enum
  - pattern enum
  - LFSR taps constant 32'h80200003
  - LFSR next-state function
- Sub-module `sdram_pattern_gen`: holds the LFSR register and produces the expected/write word from pattern, address, seed, const data, plus load and advance controls. It is shared by the write and read phases.

## Test plan
- Single write then read:
  - `isingle_addr`=0x1, `isingle_data`=0x2A5, controller model acks in 2 cycles.
  - Required: one write with data 0x2A5, then one read; `oread_data`=0x2A5, `opass`=1, one `odone` per operation.
- Sweep with ADDR pattern, base=0x3FFFFE, len=4:
  - Required: writes to 0x3FFFFE, 0x3FFFFF, 0x0, 0x1 (wrap), reads in the same order.
  - `oerr_count`=0, `opass`=1.
- Sweep with LFSR pattern, seed=0:
  - Required: first written word is 0x00000001 replicated.
  - Read phase regenerates the identical sequence; pass.
- Fault injection: model flips bit 0 on reads of 0x10 and 0x12, sweep base=0x10, len=8.
  - Required: `oerr_count`=2, `ofirst_err_addr`=0x10, `opass`=0.
- Timeout and priority:
  - `TIMEOUT_CYCLES`=16 and the model never acks: req drops after 16 cycles, `otimeout`=1, `odone` pulses.
  - Simultaneous `istart_write` and `istart_sweep`: the sweep runs.
- Edge cases:
  - `isweep_len`=0: `odone` two cycles after start, no requests.
  - `ireset_n` low during RREQ: `oread_req`=0 immediately, all status outputs cleared.
